// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the Wishbone master arbiter:
//   - arb_state_e   : arbiter FSM encoding (ARB_IDLE, ARB_BUSY)
//   - DEAD_DATA     : read data returned to a master whose transfer timed out
//   - MAX_MASTERS   : largest supported number of requesting masters
//   - IDX_W         : width of a master index (clog2 of MAX_MASTERS)
//   - onehot_to_idx : converts a one-hot grant into a master index
// Optional feature macro used by the arbiter: WB_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] DEAD_DATA   = 32'hDEADBEEF;
  localparam int          MAX_MASTERS = 8;
  localparam int          IDX_W       = $clog2(MAX_MASTERS);

  // Index of the set bit of a one-hot vector; returns 0 for an all-zero input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority encoder. Picks the first requesting
// index scanning upward from (last+1) with wrap-around to index 0.
// Ports:
//   req   in  N      request vector
//   last  in  IDX_W  index of the previous winner
//   gnt   out N      one-hot winner (0 when no request)
//   valid out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;
  logic [N-1:0] pick_src;

  // upper_mask selects the indices strictly above the previous winner; those
  // have priority over the wrapped-around lower indices.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign upper_mask[gi] = (IDX_W'(gi) > last);
  end

  assign upper_req = req & upper_mask;
  assign pick_src  = (|upper_req) ? upper_req : req;

  // x & -x isolates the lowest set bit, i.e. the first requester in scan order.
  assign gnt   = pick_src & (~pick_src + N'(1));
  assign valid = |req;

endmodule

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
// Shares the single Wishbone master port of the intercon between N_MASTERS
// bus masters. Round-robin grant, held for exactly one transfer (STB..ACK),
// with one dead cycle between transfers.
// Optional feature macro: WB_ARB_TIMEOUT_EN (watchdog that terminates a
// transfer after TIMEOUT_CYCLES BUSY cycles without ACK and sets err).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   m_STB/m_WE      per-master strobe / write enable
//   m_ADDR/m_DAT_I  packed per-master address / write data (master i at i*W)
//   m_DAT_O         read data broadcast to all masters
//   m_ACK           per-master acknowledge
//   s_STB/s_WE/s_ADDR/s_DAT_O  towards intercon master_* inputs
//   s_DAT_I/s_ACK   from intercon master_DAT_O / master_ACK
//   grant           one-hot current owner, 0 when idle
//   busy            transfer in progress
//   err             sticky timeout flag (always 0 without the watchdog)
// ---------------------------------------------------------------------------
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTERS-1:0]    m_STB,
  input  logic [N_MASTERS-1:0]    m_WE,
  input  logic [N_MASTERS*AW-1:0] m_ADDR,
  input  logic [N_MASTERS*DW-1:0] m_DAT_I,
  output logic [DW-1:0]           m_DAT_O,
  output logic [N_MASTERS-1:0]    m_ACK,
  output logic                    s_STB,
  output logic                    s_WE,
  output logic [AW-1:0]           s_ADDR,
  output logic [DW-1:0]           s_DAT_O,
  input  logic [DW-1:0]           s_DAT_I,
  input  logic                    s_ACK,
  output logic [N_MASTERS-1:0]    grant,
  output logic                    busy,
  output logic                    err
);

  arb_state_e             state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [N_MASTERS-1:0]   blocked_q, blocked_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic [N_MASTERS-1:0]   eligible;
  logic [N_MASTERS-1:0]   pick_gnt;
  logic                   pick_valid;
  logic                   in_busy;
  logic                   owner_stb;
  logic                   timeout_hit;

  assign in_busy   = (state_q == ARB_BUSY);
  assign owner_stb = |(grant_q & m_STB);
  assign eligible  = m_STB & ~blocked_q;

  rr_picker #(
    .N (N_MASTERS)
  ) u_picker (
    .req   (eligible),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Only a live transfer (owner still strobing, no ACK this cycle) can time out.
  assign timeout_hit = in_busy && owner_stb && !s_ACK &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is held at 0 outside BUSY, so it starts from 0 on every entry.
  always_comb begin
    cnt_d = '0;
    if (in_busy) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic timeout_unused;

  assign timeout_unused = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    // A master leaves the blocked set as soon as its STB is seen low.
    blocked_d = blocked_q & m_STB;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          last_d  = onehot_to_idx(MAX_MASTERS'(pick_gnt));
          state_d = ARB_BUSY;
        end
      end

      ARB_BUSY: begin
        if (s_ACK || timeout_hit) begin
          // Block the owner so a STB lingering past its ACK is not re-served.
          blocked_d = blocked_d | grant_q;
          grant_d   = '0;
          state_d   = ARB_IDLE;
        end else if (!owner_stb) begin
          // Abandoned transfer: release without blocking.
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      blocked_q <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      blocked_q <= blocked_d;
      last_q    <= last_d;
    end
  end

  // Outputs. s_STB is gated by the owner's own STB so an abandon drops it in
  // the same cycle, and by the watchdog so the slave sees the transfer end.
  assign busy  = in_busy;
  assign grant = grant_q;
  assign s_STB = in_busy && owner_stb && !timeout_hit;
  assign s_WE  = |(m_WE & grant_q);

  always_comb begin
    m_ACK = '0;
    if (in_busy) begin
      m_ACK = grant_q & {N_MASTERS{s_ACK | timeout_hit}};
    end
  end

  assign m_DAT_O = timeout_hit ? DW'(DEAD_DATA) : s_DAT_I;

  // Address / write-data mux; all zeros when nobody owns the bus.
  always_comb begin
    s_ADDR  = '0;
    s_DAT_O = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        s_ADDR  = m_ADDR[i*AW +: AW];
        s_DAT_O = m_DAT_I[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_master_arbiter
// Directed self-checking bench for wb_master_arbiter with two masters:
// reset values, single read, round-robin contention, lingering STB,
// abandon, reset mid-transfer, write path, and (with WB_ARB_TIMEOUT_EN)
// the watchdog with TIMEOUT_CYCLES=16.
// ---------------------------------------------------------------------------
module tb_wb_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_STB;
  logic [N-1:0]    m_WE;
  logic [N*AW-1:0] m_ADDR;
  logic [N*DW-1:0] m_DAT_I;
  logic [DW-1:0]   m_DAT_O;
  logic [N-1:0]    m_ACK;
  logic            s_STB;
  logic            s_WE;
  logic [AW-1:0]   s_ADDR;
  logic [DW-1:0]   s_DAT_O;
  logic [DW-1:0]   s_DAT_I;
  logic            s_ACK;
  logic [N-1:0]    grant;
  logic            busy;
  logic            err;

  int checks = 0;
  int errors = 0;

  wb_master_arbiter #(
    .N_MASTERS      (N),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_STB   (m_STB),
    .m_WE    (m_WE),
    .m_ADDR  (m_ADDR),
    .m_DAT_I (m_DAT_I),
    .m_DAT_O (m_DAT_O),
    .m_ACK   (m_ACK),
    .s_STB   (s_STB),
    .s_WE    (s_WE),
    .s_ADDR  (s_ADDR),
    .s_DAT_O (s_DAT_O),
    .s_DAT_I (s_DAT_I),
    .s_ACK   (s_ACK),
    .grant   (grant),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "bench timeout");
  end

  logic [N-1:0] exp_g;

  initial begin
    rst     = 1'b1;
    m_STB   = '0;
    m_WE    = '0;
    m_ADDR  = {32'h0000_00B0, 32'h0000_00A0};
    m_DAT_I = {32'h0000_0011, 32'h0000_0022};
    s_DAT_I = '0;
    s_ACK   = 1'b0;

    // ---- reset values
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_stb", s_STB, 0);
    chk("rst_s_we", s_WE, 0);
    chk("rst_m_ack", m_ACK, 0);
    chk("rst_err", err, 0);
    chk("rst_s_addr", s_ADDR, 0);
    chk("rst_s_dat_o", s_DAT_O, 0);
    chk("rst_m_dat_o", m_DAT_O, 0);
    rst = 1'b0;
    tick();

    // ---- single master read at 0x100, slave ACKs 3 cycles after s_STB
    m_ADDR[0 +: AW] = 32'h0000_0100;
    m_STB = 2'b01;
    #1;
    chk("single_no_stb_yet", s_STB, 0);
    tick();
    chk("single_s_stb", s_STB, 1);
    chk("single_grant", grant, 2'b01);
    chk("single_busy", busy, 1);
    chk("single_s_addr", s_ADDR, 32'h100);
    chk("single_s_we", s_WE, 0);
    tick();
    chk("single_wait_ack", m_ACK, 0);
    tick();
    tick();
    s_ACK   = 1'b1;
    s_DAT_I = 32'h1234_5678;
    #1;
    chk("single_m_ack", m_ACK, 2'b01);
    chk("single_m_dat_o", m_DAT_O, 32'h1234_5678);
    $display("txn single: master 0 read addr %h data %h", s_ADDR, m_DAT_O);
    tick();
    s_ACK   = 1'b0;
    s_DAT_I = '0;
    m_STB   = 2'b00;
    #1;
    chk("single_idle_busy", busy, 0);
    chk("single_idle_grant", grant, 0);
    chk("single_idle_stb", s_STB, 0);
    tick();

    // ---- contention: both request, last=0 so order is M1,M0,M1,M0
    m_ADDR[0 +: AW] = 32'h0000_00A0;
    m_STB = 2'b11;
    #1;
    chk("cont_no_stb_yet", s_STB, 0);
    tick();
    exp_g = 2'b10;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("cont%0d_s_stb", t), s_STB, 1);
      chk($sformatf("cont%0d_grant", t), grant, exp_g);
      chk($sformatf("cont%0d_s_addr", t), s_ADDR, (exp_g == 2'b01) ? 32'hA0 : 32'hB0);
      s_ACK = 1'b1;
      #1;
      chk($sformatf("cont%0d_m_ack", t), m_ACK, exp_g);
      $display("txn contention %0d: grant %b addr %h", t, grant, s_ADDR);
      tick();
      s_ACK = 1'b0;
      m_STB = (t == 3) ? 2'b00 : (m_STB & ~exp_g);
      #1;
      chk($sformatf("cont%0d_gap_stb", t), s_STB, 0);
      chk($sformatf("cont%0d_gap_busy", t), busy, 0);
      if (t < 3) begin
        tick();
        m_STB = 2'b11;
        exp_g = ~exp_g;
      end
    end
    tick();
    chk("cont_done_busy", busy, 0);

    // ---- lingering STB: M0 keeps STB one cycle past its ACK
    m_STB = 2'b01;
    tick();
    chk("ling_s_stb", s_STB, 1);
    s_ACK = 1'b1;
    #1;
    chk("ling_m_ack", m_ACK, 2'b01);
    $display("txn linger: master 0 addr %h", s_ADDR);
    tick();
    s_ACK = 1'b0;
    #1;
    chk("ling_dead_stb", s_STB, 0);
    tick();
    chk("ling_blocked_stb", s_STB, 0);
    chk("ling_blocked_grant", grant, 0);
    m_STB = 2'b00;
    tick();
    m_STB = 2'b01;
    #1;
    chk("ling_rerise_stb", s_STB, 0);
    tick();
    chk("ling_regrant_stb", s_STB, 1);
    chk("ling_regrant_grant", grant, 2'b01);
    s_ACK = 1'b1;
    #1;
    $display("txn linger: master 0 re-served addr %h", s_ADDR);
    tick();
    s_ACK = 1'b0;
    m_STB = 2'b00;
    tick();

    // ---- abandon: M1 drops STB 2 cycles into BUSY, M0 waiting
    m_STB = 2'b11;
    tick();
    chk("abn_grant_m1", grant, 2'b10);
    chk("abn_s_stb", s_STB, 1);
    tick();
    m_STB = 2'b01;
    #1;
    chk("abn_stb_dropped", s_STB, 0);
    chk("abn_no_ack", m_ACK, 0);
    $display("txn abandon: master 1 dropped STB");
    tick();
    chk("abn_idle_grant", grant, 0);
    chk("abn_idle_stb", s_STB, 0);
    tick();
    chk("abn_next_grant", grant, 2'b01);
    chk("abn_next_addr", s_ADDR, 32'hA0);

    // ---- reset mid-transfer, then a late ACK must be ignored
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_STB = 2'b00;
    s_ACK = 1'b1;
    #1;
    chk("rmid_grant", grant, 0);
    chk("rmid_s_stb", s_STB, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_late_ack", m_ACK, 0);
    $display("txn reset: in-flight transfer dropped");
    tick();
    s_ACK = 1'b0;
    chk("rmid_still_idle", busy, 0);

    // ---- write from M1
    m_WE = 2'b10;
    m_DAT_I[1*DW +: DW] = 32'hCAFE_F00D;
    m_STB = 2'b10;
    tick();
    chk("wr_grant", grant, 2'b10);
    chk("wr_s_we", s_WE, 1);
    chk("wr_s_dat_o", s_DAT_O, 32'hCAFE_F00D);
    chk("wr_s_addr", s_ADDR, 32'hB0);
    s_ACK = 1'b1;
    #1;
    chk("wr_m_ack", m_ACK, 2'b10);
    $display("txn write: master 1 addr %h data %h", s_ADDR, s_DAT_O);
    tick();
    s_ACK = 1'b0;
    m_STB = 2'b00;
    m_WE  = 2'b00;
    #1;
    chk("wr_err_clear", err, 0);
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // ---- watchdog: no ACK; pulse in the 16th BUSY cycle
    m_STB = 2'b01;
    tick();
    chk("to_s_stb", s_STB, 1);
    for (int c = 1; c < 15; c++) begin
      tick();
    end
    chk("to_pre_ack", m_ACK, 0);
    tick();
    chk("to_m_ack", m_ACK, 2'b01);
    chk("to_m_dat_o", m_DAT_O, 32'hDEAD_BEEF);
    chk("to_s_stb_low", s_STB, 0);
    $display("txn timeout: master 0 data %h", m_DAT_O);
    tick();
    m_STB = 2'b00;
    #1;
    chk("to_err_set", err, 1);
    chk("to_busy", busy, 0);
    tick();
    tick();
    chk("to_err_sticky", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_err_rst", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
